// File: rtl/carrier_generator.sv
// carrier_generator: runtime-configurable triangle / sawtooth PWM carrier with
// boundary pulses for duty-cycle reload and sync.
module carrier_generator #(
    parameter int WIDTH  = 6,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  peak,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              at_peak,
    output logic              at_zero,
    output logic              period_start
);
    typedef enum logic [1:0] {M_TRI = 2'b00, M_UP = 2'b01, M_DN = 2'b10, M_HOLD = 2'b11} mode_e;
    // Wide enough that count+step never wraps, whichever input is wider.
    localparam int XW = (WIDTH > STEP_W ? WIDTH : STEP_W) + 1;
    mode_e            mode_m;
    logic             adv;
    logic [XW-1:0]    s_x, cnt_x, pk_x, sum_x;
    logic [WIDTH-1:0] s_w;
    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             at_peak_q, at_peak_d;
    logic             at_zero_q, at_zero_d;
    logic             ps_q, ps_d;
    assign mode_m = mode_e'(mode);
    assign adv    = en && mode_m != M_HOLD;
    assign s_x    = (step == '0) ? XW'(1) : {{(XW-STEP_W){1'b0}}, step};
    assign cnt_x  = {{(XW-WIDTH){1'b0}}, count_q};
    assign pk_x   = {{(XW-WIDTH){1'b0}}, peak};
    assign sum_x  = cnt_x + s_x;
    assign s_w    = s_x[WIDTH-1:0];
    always_comb begin
        count_d   = count_q;
        dir_d     = dir_q;
        at_peak_d = 1'b0;
        at_zero_d = 1'b0;
        ps_d      = 1'b0;
        if (adv) begin
            if (peak == '0) begin
                count_d = '0;
                dir_d   = 1'b1;
            end else if (mode_m == M_TRI) begin
                if (dir_q) begin
                    count_d = (sum_x >= pk_x) ? peak : count_q + s_w;
                    dir_d   = !(sum_x >= pk_x);
                end else begin
                    count_d = (cnt_x <= s_x) ? '0 : count_q - s_w;
                    dir_d   = cnt_x <= s_x;
                end
            end else if (mode_m == M_UP) begin
                count_d = (cnt_x >= pk_x) ? '0 : (sum_x >= pk_x) ? peak : count_q + s_w;
                dir_d   = 1'b1;
            end else begin
                count_d = (count_q == '0) ? peak : (cnt_x <= s_x) ? '0 : count_q - s_w;
                dir_d   = 1'b0;
            end
            at_peak_d = peak != '0 && count_d == peak;
            at_zero_d = count_d == '0;
            // Saw-down periods restart at the top; the others restart at zero.
            ps_d      = (mode_m == M_DN && peak != '0) ? at_peak_d : at_zero_d;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            dir_q     <= 1'b1;
            at_peak_q <= 1'b0;
            at_zero_q <= 1'b0;
            ps_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            dir_q     <= dir_d;
            at_peak_q <= at_peak_d;
            at_zero_q <= at_zero_d;
            ps_q      <= ps_d;
        end
    end
    assign count        = count_q;
    assign dir          = dir_q;
    assign at_peak      = at_peak_q;
    assign at_zero      = at_zero_q;
    assign period_start = ps_q;
endmodule

// File: tb/tb_carrier_generator.sv
// tb_carrier_generator: vector table, directed corner sequences and randomized
// run against an arithmetic carrier model.
module tb_carrier_generator;
    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] mode;
    logic [5:0] peak;
    logic [3:0] step;
    logic [5:0] count;
    logic       dir, at_peak, at_zero, period_start;
    int pass_cnt = 0;
    int total_cnt = 0;
    int m_cnt = 0;
    bit m_dir = 1'b1, m_ap = 1'b0, m_az = 1'b0, m_ps = 1'b0;
    typedef struct {
        int r, e, m, p, s, cnt;
        logic [3:0] fl;
    } vec_t;
    vec_t tv[$];
    carrier_generator #(.WIDTH(6), .STEP_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .peak(peak), .step(step),
        .count(count), .dir(dir), .at_peak(at_peak), .at_zero(at_zero),
        .period_start(period_start)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
    function automatic vec_t v(int r, int e, int m, int p, int s, int c, logic [3:0] f);
        vec_t x;
        x.r = r; x.e = e; x.m = m; x.p = p; x.s = s; x.cnt = c; x.fl = f;
        return x;
    endfunction
    task automatic chk(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    // Carrier behaviour from the rules, in plain integers.
    task automatic ref_step(int r, int e, int md, int pk, int st);
        int s;
        m_ap = 0; m_az = 0; m_ps = 0;
        if (r != 0) begin
            m_cnt = 0; m_dir = 1;
            return;
        end
        if (e == 0 || md == 3) return;
        s = (st == 0) ? 1 : st;
        if (pk == 0) begin
            m_cnt = 0; m_dir = 1; m_az = 1; m_ps = 1;
            return;
        end
        if (md == 0) begin
            if (m_dir) begin
                if (m_cnt + s >= pk) begin m_cnt = pk; m_dir = 0; end
                else m_cnt = m_cnt + s;
            end else begin
                if (m_cnt - s <= 0) begin m_cnt = 0; m_dir = 1; end
                else m_cnt = m_cnt - s;
            end
        end else if (md == 1) begin
            m_dir = 1;
            m_cnt = (m_cnt >= pk) ? 0 : (m_cnt + s < pk) ? m_cnt + s : pk;
        end else begin
            m_dir = 0;
            m_cnt = (m_cnt == 0) ? pk : (m_cnt - s > 0) ? m_cnt - s : 0;
        end
        m_ap = (m_cnt == pk);
        m_az = (m_cnt == 0);
        m_ps = (md == 2) ? m_ap : m_az;
    endtask
    task automatic drive(int r, int e, int m, int p, int s);
        rst = 1'(r); en = 1'(e); mode = 2'(m); peak = 6'(p); step = 4'(s);
        @(posedge clk);
        ref_step(r, e, m, p, s);
        #1;
    endtask
    function automatic int flags();
        return int'({dir, at_peak, at_zero, period_start});
    endfunction
    initial begin
        int ec, p, r, e, md, pk, st;
        logic [3:0] ef;
        tv.push_back(v(1, 1, 0, 20, 5, 0, 4'b1000));
        tv.push_back(v(0, 1, 0, 20, 5, 5, 4'b1000));
        tv.push_back(v(0, 1, 0, 20, 5, 10, 4'b1000));
        tv.push_back(v(0, 1, 0, 20, 5, 15, 4'b1000));
        tv.push_back(v(0, 1, 0, 20, 5, 20, 4'b0100));
        tv.push_back(v(0, 1, 0, 20, 5, 15, 4'b0000));
        tv.push_back(v(0, 1, 0, 20, 5, 10, 4'b0000));
        tv.push_back(v(0, 1, 0, 20, 5, 5, 4'b0000));
        tv.push_back(v(0, 1, 0, 20, 5, 0, 4'b1011));
        tv.push_back(v(0, 1, 0, 20, 5, 5, 4'b1000));
        tv.push_back(v(1, 1, 1, 9, 4, 0, 4'b1000));
        tv.push_back(v(0, 1, 1, 9, 4, 4, 4'b1000));
        tv.push_back(v(0, 1, 1, 9, 4, 8, 4'b1000));
        tv.push_back(v(0, 1, 1, 9, 4, 9, 4'b1100));
        tv.push_back(v(0, 1, 1, 9, 4, 0, 4'b1011));
        tv.push_back(v(0, 1, 1, 9, 4, 4, 4'b1000));
        tv.push_back(v(1, 1, 2, 9, 4, 0, 4'b1000));
        tv.push_back(v(0, 1, 2, 9, 4, 9, 4'b0101));
        tv.push_back(v(0, 1, 2, 9, 4, 5, 4'b0000));
        tv.push_back(v(0, 1, 2, 9, 4, 1, 4'b0000));
        tv.push_back(v(0, 1, 2, 9, 4, 0, 4'b0010));
        tv.push_back(v(0, 1, 2, 9, 4, 9, 4'b0101));
        rst = 1'b1; en = 1'b0; mode = 2'd0; peak = 6'd0; step = 4'd0;
        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].e, tv[i].m, tv[i].p, tv[i].s);
            chk($sformatf("tab%0d_count", i), int'(count), tv[i].cnt);
            chk($sformatf("tab%0d_flags", i), flags(), int'(tv[i].fl));
        end
        // Full-range triangle, two periods of 126 cycles.
        drive(1, 1, 0, 63, 1);
        chk("t1_reset_count", int'(count), 0);
        chk("t1_reset_flags", flags(), 8);
        for (int k = 1; k <= 252; k++) begin
            drive(0, 1, 0, 63, 1);
            p = k % 126;
            ec = (p <= 63) ? p : 126 - p;
            ef = {p < 63, p == 63, p == 0, p == 0};
            chk($sformatf("t1_count_k%0d", k), int'(count), ec);
            chk($sformatf("t1_flags_k%0d", k), flags(), int'(ef));
        end
        // Freeze via en=0 and via mode=11.
        drive(1, 1, 0, 63, 1);
        repeat (30) drive(0, 1, 0, 63, 1);
        chk("t4_count30", int'(count), 30);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 63, 1);
            chk("t4_frozen_count", int'(count), 30);
            chk("t4_frozen_flags", flags(), 8);
        end
        drive(0, 1, 0, 63, 1);
        chk("t4_resume", int'(count), 31);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 3, 63, 1);
            chk("t4_hold_count", int'(count), 31);
            chk("t4_hold_flags", flags(), 8);
        end
        drive(0, 1, 0, 63, 1);
        chk("t4_after_hold", int'(count), 32);
        // Peak lowered under an up-going count, then step=0, then peak=0.
        repeat (8) drive(0, 1, 0, 63, 1);
        chk("t5_count40", int'(count), 40);
        drive(0, 1, 0, 25, 1);
        chk("t5_clamp_count", int'(count), 25);
        chk("t5_clamp_flags", flags(), 4);
        drive(0, 1, 0, 25, 0);
        chk("t5_step0_a", int'(count), 24);
        drive(0, 1, 0, 25, 0);
        chk("t5_step0_b", int'(count), 23);
        drive(1, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, 1);
            chk("t5_pk0_count", int'(count), 0);
            chk("t5_pk0_dir_az_ps", int'({dir, at_zero, period_start}), 7);
        end
        // Reset in the middle of a descent.
        drive(1, 1, 0, 63, 1);
        repeat (109) drive(0, 1, 0, 63, 1);
        chk("t6_count17", int'(count), 17);
        chk("t6_dir_down", int'(dir), 0);
        drive(1, 1, 0, 63, 1);
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_flags", flags(), 8);
        drive(0, 1, 0, 63, 1);
        chk("t6_after_rst", int'(count), 1);
        // Randomized run against the model.
        drive(1, 1, 0, 40, 1);
        md = 0; pk = 40;
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom % 100 == 0) ? 1 : 0;
            e  = ($urandom % 4 != 0) ? 1 : 0;
            if ($urandom % 10 == 0) md = int'($urandom % 4);
            if ($urandom % 20 == 0) pk = int'($urandom_range(1, 63));
            st = int'($urandom % 16);
            drive(r, e, md, pk, st);
            chk($sformatf("rnd%0d_count", k), int'(count), m_cnt);
            chk($sformatf("rnd%0d_flags", k), flags(), int'({m_dir, m_ap, m_az, m_ps}));
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
